// File: rtl/escalonador_ativo.sv
// escalonador_ativo: sequencer/selector in front of the active-node classifier.
// On a request it pulses the classifier update and waits for its ready pulse.
// It then scans the node array for the lowest-index active node holding the
// global minimum criterion, and returns the result over valid/ready.
// Empty node sets and classifier timeouts are reported, so the requester
// never stalls.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   sel_req_in            selection request (sampled only when idle)
//   sel_busy_o            registered "not idle" flag
//   na_ativo_in           per-node active flags
//   na_criterio_in        packed per-node criteria, node i at [CW*i +: CW]
//   ea_atualizar_o        one-cycle update pulse to the classifier
//   ca_pronto_in          classifier ready pulse
//   ca_criterio_geral_in  classifier global minimum criterion
//   sel_valid_o           result valid, held until sel_ready_in
//   sel_ready_in          requester accepts the result
//   sel_idx_o             selected node index
//   sel_criterio_o        selected node criterion
//   sel_vazio_o           no active node existed
//   sel_erro_o            timeout or no matching node
module escalonador_ativo #(
  parameter int NUM_NA         = 8,
  parameter int CRITERIO_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               sel_req_in,
  output logic                               sel_busy_o,
  input  logic [NUM_NA-1:0]                  na_ativo_in,
  input  logic [NUM_NA*CRITERIO_WIDTH-1:0]   na_criterio_in,
  output logic                               ea_atualizar_o,
  input  logic                               ca_pronto_in,
  input  logic [CRITERIO_WIDTH-1:0]          ca_criterio_geral_in,
  output logic                               sel_valid_o,
  input  logic                               sel_ready_in,
  output logic [$clog2(NUM_NA)-1:0]          sel_idx_o,
  output logic [CRITERIO_WIDTH-1:0]          sel_criterio_o,
  output logic                               sel_vazio_o,
  output logic                               sel_erro_o
);

  localparam int IDX_WIDTH = $clog2(NUM_NA);
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NA - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    OCIOSO,
    DISPARO,
    ESPERA,
    BUSCA,
    ENTREGA
  } estado_t;

  estado_t                   estado_q, estado_d;
  logic                      busy_q;
  logic [IDX_WIDTH-1:0]      idx_q, idx_d;
  logic [CRITERIO_WIDTH-1:0] crit_q, crit_d;
  logic                      vazio_q, vazio_d;
  logic                      erro_q, erro_d;
  logic [CRITERIO_WIDTH-1:0] min_q, min_d;
  logic [IDX_WIDTH-1:0]      scan_q, scan_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

  // Node under test at the current scan index.
  logic                      node_ativo;
  logic [CRITERIO_WIDTH-1:0] node_crit;

  always_comb begin
    node_ativo = 1'b0;
    node_crit  = '0;
    for (int unsigned i = 0; i < NUM_NA; i++) begin
      if (scan_q == IDX_WIDTH'(i)) begin
        node_ativo = na_ativo_in[i];
        node_crit  = na_criterio_in[i*CRITERIO_WIDTH +: CRITERIO_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      busy_q   <= 1'b0;
      idx_q    <= '0;
      crit_q   <= '1;
      vazio_q  <= 1'b0;
      erro_q   <= 1'b0;
      min_q    <= '0;
      scan_q   <= '0;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      busy_q   <= (estado_d != OCIOSO);
      idx_q    <= idx_d;
      crit_q   <= crit_d;
      vazio_q  <= vazio_d;
      erro_q   <= erro_d;
      min_q    <= min_d;
      scan_q   <= scan_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    estado_d       = estado_q;
    idx_d          = idx_q;
    crit_d         = crit_q;
    vazio_d        = vazio_q;
    erro_d         = erro_q;
    min_d          = min_q;
    scan_d         = scan_q;
    cnt_d          = cnt_q;
    ea_atualizar_o = 1'b0;
    sel_valid_o    = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (sel_req_in) begin
          if (na_ativo_in == '0) begin
            vazio_d  = 1'b1;
            idx_d    = '0;
            crit_d   = '1;
            erro_d   = 1'b0;
            estado_d = ENTREGA;
          end else begin
            vazio_d  = 1'b0;
            erro_d   = 1'b0;
            estado_d = DISPARO;
          end
        end
      end

      DISPARO: begin
        ea_atualizar_o = 1'b1;
        cnt_d          = '0;
        estado_d       = ESPERA;
      end

      ESPERA: begin
        // Pronto takes priority over a timeout landing in the same cycle.
        if (ca_pronto_in) begin
          min_d    = ca_criterio_geral_in;
          scan_d   = '0;
          estado_d = BUSCA;
        end else if (cnt_q == LAST_CNT) begin
          erro_d   = 1'b1;
          idx_d    = '0;
          crit_d   = '1;
          estado_d = ENTREGA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      BUSCA: begin
        if (node_ativo && (node_crit == min_q)) begin
          idx_d    = scan_q;
          crit_d   = min_q;
          estado_d = ENTREGA;
        end else if (scan_q == LAST_IDX) begin
          erro_d   = 1'b1;
          idx_d    = '0;
          crit_d   = min_q;
          estado_d = ENTREGA;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end

      ENTREGA: begin
        sel_valid_o = 1'b1;
        if (sel_ready_in) estado_d = OCIOSO;
      end

      default: estado_d = OCIOSO;
    endcase
  end

  assign sel_busy_o     = busy_q;
  assign sel_idx_o      = idx_q;
  assign sel_criterio_o = crit_q;
  assign sel_vazio_o    = vazio_q;
  assign sel_erro_o     = erro_q;

endmodule

// File: tb/tb_escalonador_ativo.sv
// Testbench for escalonador_ativo: table of request vectors with hand-derived
// expected results pushed to a scoreboard, a classifier model answering the
// update pulse NUM_NA cycles later, plus reset and backpressure sequences.
module tb_escalonador_ativo;

  localparam int NA = 8;
  localparam int CW = 5;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sel_req_in;
  logic          sel_busy_o;
  logic [NA-1:0] na_ativo_in;
  logic [NA*CW-1:0] na_criterio_in;
  logic          ea_atualizar_o;
  logic          ca_pronto_in;
  logic [CW-1:0] ca_criterio_geral_in;
  logic          sel_valid_o;
  logic          sel_ready_in;
  logic [2:0]    sel_idx_o;
  logic [CW-1:0] sel_criterio_o;
  logic          sel_vazio_o;
  logic          sel_erro_o;

  escalonador_ativo #(
    .NUM_NA(NA),
    .CRITERIO_WIDTH(CW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sel_req_in(sel_req_in),
    .sel_busy_o(sel_busy_o),
    .na_ativo_in(na_ativo_in),
    .na_criterio_in(na_criterio_in),
    .ea_atualizar_o(ea_atualizar_o),
    .ca_pronto_in(ca_pronto_in),
    .ca_criterio_geral_in(ca_criterio_geral_in),
    .sel_valid_o(sel_valid_o),
    .sel_ready_in(sel_ready_in),
    .sel_idx_o(sel_idx_o),
    .sel_criterio_o(sel_criterio_o),
    .sel_vazio_o(sel_vazio_o),
    .sel_erro_o(sel_erro_o)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0]  ativo;
    logic [39:0] crit;
    logic        pronto;
    logic [4:0]  cls;
    logic [2:0]  idx;
    logic [4:0]  crit_o;
    logic        vazio;
    logic        erro;
    int          lat;
  } vec_t;

  typedef struct {
    logic [2:0] idx;
    logic [4:0] crit;
    logic       vazio;
    logic       erro;
    int         cyc;
    int         id;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  function automatic logic [39:0] pk(input int a0, input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6, input int a7);
    return {5'(a7), 5'(a6), 5'(a5), 5'(a4), 5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  // Classifier model: answers an update pulse with pronto NUM_NA cycles later.
  logic       cls_en  = 1'b0;
  logic [4:0] cls_val = '0;
  int         cls_cnt = 0;

  always @(negedge clk) begin
    ca_pronto_in = 1'b0;
    if (!rst_n) begin
      cls_cnt = 0;
    end else begin
      if (cls_cnt > 0) begin
        cls_cnt--;
        if (cls_cnt == 0) begin
          ca_pronto_in         = 1'b1;
          ca_criterio_geral_in = cls_val;
        end
      end
      if (ea_atualizar_o && cls_en) cls_cnt = NA;
    end
  end

  // Scoreboard monitor: pops one expected result on every rising valid.
  logic valid_prev = 1'b0;
  int   upd_cnt    = 0;
  int   upd_cyc    = -1;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && sel_valid_o && !valid_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_valid_cycle", e.id), cyc, e.cyc);
        chk($sformatf("v%0d_idx", e.id), sel_idx_o, e.idx);
        chk($sformatf("v%0d_crit", e.id), sel_criterio_o, e.crit);
        chk($sformatf("v%0d_vazio", e.id), sel_vazio_o, e.vazio);
        chk($sformatf("v%0d_erro", e.id), sel_erro_o, e.erro);
      end
    end
    valid_prev = sel_valid_o;
    if (ea_atualizar_o) begin
      upd_cnt++;
      upd_cyc = cyc;
    end
  end

  task automatic chk_reset_values(input string tag);
    chk({tag, "_busy"}, sel_busy_o, 0);
    chk({tag, "_atualizar"}, ea_atualizar_o, 0);
    chk({tag, "_valid"}, sel_valid_o, 0);
    chk({tag, "_idx"}, sel_idx_o, 0);
    chk({tag, "_crit"}, sel_criterio_o, 5'h1F);
    chk({tag, "_vazio"}, sel_vazio_o, 0);
    chk({tag, "_erro"}, sel_erro_o, 0);
  endtask

  task automatic wait_valid(input string tag, output logic seen);
    int n = 0;
    while (!sel_valid_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    seen = sel_valid_o;
    if (!seen) begin
      chk({tag, "_valid_timeout"}, 0, 1);
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int   c0;
    logic seen;
    @(negedge clk);
    na_ativo_in    = v.ativo;
    na_criterio_in = v.crit;
    cls_en         = v.pronto;
    cls_val        = v.cls;
    sel_ready_in   = 1'b1;
    upd_cnt        = 0;
    upd_cyc        = -1;
    c0             = cyc;
    sb.push_back('{v.idx, v.crit_o, v.vazio, v.erro, c0 + v.lat, id});
    sel_req_in     = 1'b1;
    @(negedge clk);
    sel_req_in = 1'b0;
    chk($sformatf("v%0d_busy_c1", id), sel_busy_o, 1);
    wait_valid($sformatf("v%0d", id), seen);
    if (seen) begin
      @(negedge clk);
      chk($sformatf("v%0d_valid_after_accept", id), sel_valid_o, 0);
      chk($sformatf("v%0d_busy_after_accept", id), sel_busy_o, 0);
      chk($sformatf("v%0d_upd_count", id), upd_cnt, v.vazio ? 0 : 1);
      if (!v.vazio) chk($sformatf("v%0d_upd_cycle", id), upd_cyc, c0 + 1);
    end
  endtask

  initial begin
    logic seen;
    int   c0;

    // inputs, classifier value, pronto, expected idx/crit/vazio/erro, latency
    vecs[0] = '{8'b0111_1111, pk(3, 7, 2, 9, 2, 5, 6, 1), 1'b1, 5'd2, 3'd2, 5'd2, 1'b0, 1'b0, 13};
    vecs[1] = '{8'h00, pk(3, 7, 2, 9, 2, 5, 6, 1), 1'b1, 5'd2, 3'd0, 5'h1F, 1'b1, 1'b0, 1};
    vecs[2] = '{8'hFF, pk(3, 7, 2, 9, 2, 5, 6, 1), 1'b0, 5'd2, 3'd0, 5'h1F, 1'b0, 1'b1, 18};
    vecs[3] = '{8'b0111_1111, pk(3, 7, 2, 9, 2, 5, 6, 1), 1'b1, 5'd4, 3'd0, 5'd4, 1'b0, 1'b1, 18};
    vecs[4] = '{8'hFF, pk(0, 1, 2, 3, 4, 5, 6, 7), 1'b1, 5'd0, 3'd0, 5'd0, 1'b0, 1'b0, 11};
    vecs[5] = '{8'h80, pk(31, 31, 31, 31, 31, 31, 31, 31), 1'b1, 5'd31, 3'd7, 5'd31, 1'b0, 1'b0, 18};
    vecs[6] = '{8'b0010_0000, pk(5, 5, 5, 5, 5, 5, 5, 5), 1'b1, 5'd5, 3'd5, 5'd5, 1'b0, 1'b0, 16};
    vecs[7] = '{8'hFF, pk(16, 0, 31, 31, 31, 31, 31, 31), 1'b1, 5'd0, 3'd1, 5'd0, 1'b0, 1'b0, 12};

    rst_n                = 1'b0;
    sel_req_in           = 1'b0;
    sel_ready_in         = 1'b0;
    na_ativo_in          = '0;
    na_criterio_in       = '0;
    ca_criterio_geral_in = '0;
    repeat (3) @(negedge clk);
    chk_reset_values("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", sel_busy_o, 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset while scanning: no result may be delivered afterwards.
    @(negedge clk);
    na_ativo_in    = vecs[0].ativo;
    na_criterio_in = vecs[0].crit;
    cls_en         = 1'b1;
    cls_val        = 5'd2;
    sel_ready_in   = 1'b1;
    sel_req_in     = 1'b1;
    @(negedge clk);
    sel_req_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("midbusca_busy", sel_busy_o, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_values("midbusca_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_busy", sel_busy_o, 0);
    chk("post_rst_valid", sel_valid_o, 0);
    run_vec(vecs[0], 10);

    // Backpressure: result held, a request during ENTREGA is ignored.
    @(negedge clk);
    na_ativo_in    = vecs[0].ativo;
    na_criterio_in = vecs[0].crit;
    cls_en         = 1'b1;
    cls_val        = 5'd2;
    sel_ready_in   = 1'b0;
    upd_cnt        = 0;
    c0             = cyc;
    sb.push_back('{3'd2, 5'd2, 1'b0, 1'b0, c0 + 13, 20});
    sel_req_in     = 1'b1;
    @(negedge clk);
    sel_req_in = 1'b0;
    wait_valid("bp", seen);
    if (seen) begin
      for (int j = 0; j < 5; j++) begin
        sel_req_in = (j == 1);
        @(negedge clk);
        chk($sformatf("bp%0d_valid", j), sel_valid_o, 1);
        chk($sformatf("bp%0d_idx", j), sel_idx_o, 2);
        chk($sformatf("bp%0d_crit", j), sel_criterio_o, 2);
        chk($sformatf("bp%0d_erro_vazio", j), {sel_erro_o, sel_vazio_o}, 0);
        chk($sformatf("bp%0d_upd", j), upd_cnt, 1);
      end
      sel_req_in   = 1'b0;
      sel_ready_in = 1'b1;
      @(negedge clk);
      chk("bp_valid_after_accept", sel_valid_o, 0);
      chk("bp_busy_after_accept", sel_busy_o, 0);
      repeat (3) @(negedge clk);
      chk("bp_req_not_queued_busy", sel_busy_o, 0);
      chk("bp_req_not_queued_upd", upd_cnt, 1);
    end
    run_vec(vecs[1], 21);
    run_vec(vecs[0], 22);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/escalonador_ativo.md
# escalonador_ativo

Sequencer and selector in front of the active-node classifier. On a selection request it pulses the classifier's update input and waits for its ready pulse, capturing the global minimum criterion. It then scans the node array for the lowest-index active node holding that criterion and returns that node's index and criterion to the requester over a valid/ready handshake. It also flags an empty node set and a classifier timeout, so the search controller never stalls on a missing node.

## Interface
- NUM_NA, 8, number of nodes; IDX_WIDTH = $clog2(NUM_NA) (local)
- CRITERIO_WIDTH, 5, width of one node criterion
- TIMEOUT_CYCLES, 16, maximum cycles spent in ESPERA before declaring an error; must be > NUM_NA

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sel_req_in  in  1  selection request; sampled only in OCIOSO
- sel_busy_o  out  1  high in every state except OCIOSO
- na_ativo_in  in  NUM_NA  active flag per node
- na_criterio_in  in  NUM_NA*CRITERIO_WIDTH  packed criteria; node i at [CW*i+CW-1:CW*i]
- ea_atualizar_o  out  1  one-cycle update pulse to the classifier
- ca_pronto_in  in  1  classifier ready pulse
- ca_criterio_geral_in  in  CRITERIO_WIDTH  classifier minimum criterion
- sel_valid_o  out  1  result valid; held until accepted
- sel_ready_in  in  1  requester accepts the result
- sel_idx_o  out  IDX_WIDTH  selected node index
- sel_criterio_o  out  CRITERIO_WIDTH  selected node criterion
- sel_vazio_o  out  1  no active node existed
- sel_erro_o  out  1  timeout or no matching node found

## Operation
- FSM states: OCIOSO, DISPARO, ESPERA, BUSCA, ENTREGA.
- **OCIOSO**
  - sel_req_in=1 and na_ativo_in==0: load sel_vazio=1, idx=0, criterio=all ones, erro=0, then go to ENTREGA.
  - sel_req_in=1 otherwise: clear vazio and erro, then go to DISPARO.
- **DISPARO:** ea_atualizar_o=1 for exactly this cycle; clear the timeout counter; go to ESPERA.
- **ESPERA**
  - Timeout counter increments every cycle.
  - ca_pronto_in=1: capture ca_criterio_geral_in into an internal min register, clear the scan index, go to BUSCA.
  - Counter reaches TIMEOUT_CYCLES-1 with no pronto: set erro=1, idx=0, criterio=all ones, go to ENTREGA.
  - Pronto and timeout in the same cycle: pronto wins.
- **BUSCA**
  - Tests one node per cycle at scan index k, from 0 upward.
  - Match condition: na_ativo_in[k] && criterio[k]==min.
  - First match: sel_idx=k, sel_criterio=min, go to ENTREGA.
  - k==NUM_NA-1 without a match: erro=1, idx=0, criterio=min, go to ENTREGA.
  - Ties resolve to the lowest index.
- **ENTREGA:** sel_valid_o=1 with idx/criterio/vazio/erro held stable; sel_ready_in=1 returns the FSM to OCIOSO on the next edge.
- sel_req_in outside OCIOSO is ignored, not queued.
- na_ativo_in and na_criterio_in must be stable from request acceptance until sel_valid_o; the block uses them live.
- Comparisons are unsigned, full CRITERIO_WIDTH. The scan index and timeout counter saturate at their terminal values, with no wrap.

## Timing
- **Reset values:** sel_busy_o=0, ea_atualizar_o=0, sel_valid_o=0, sel_idx_o=0, sel_criterio_o=all ones, sel_vazio_o=0, sel_erro_o=0. State OCIOSO, counters 0.
- Reset mid-operation: the FSM aborts immediately to OCIOSO and no pending result is delivered.
- Cycle numbering: cycle 0 is the cycle sel_req_in is sampled high.
- **Empty set:** sel_valid_o high in cycle 1; no ea_atualizar_o pulse.
- **Normal path:**
  - ea_atualizar_o high in cycle 1.
  - The classifier returns pronto in cycle NUM_NA+1.
  - BUSCA tests index k in cycle NUM_NA+2+k.
  - sel_valid_o rises in cycle NUM_NA+3+k.
- **Timeout:** ESPERA spans cycles 2..TIMEOUT_CYCLES+1; sel_valid_o with erro rises in cycle TIMEOUT_CYCLES+2.
- sel_busy_o is a registered decode of state ≠ OCIOSO; it is high from cycle 1 until the cycle after acceptance.
- Outputs are stable throughout ENTREGA. Result fields keep their last value in OCIOSO until the next load.

## Test plan
- **Reset:** assert rst_n=0 mid-BUSCA → all outputs return to their reset values asynchronously; after release, sel_busy_o=0 and a new request is accepted.
- **Normal selection:** criteria {3,7,2,9,2,5,6,1}, ativo=8'b0111_1111, classifier model returns 2 → sel_idx_o=2 and sel_criterio_o=2 at cycle 13; vazio=0, erro=0; one atualizar pulse at cycle 1.
- **Empty set:** ativo=8'h00 → sel_valid_o in cycle 1 with vazio=1, idx=0, criterio=5'h1F; ea_atualizar_o never asserted.
- **Timeout:** ativo=8'hFF, pronto held low → sel_valid_o with erro=1 at cycle 18, idx=0, criterio=5'h1F.
- **Inconsistent classifier:** model returns 4, which matches no active node → BUSCA scans all 8 nodes; sel_valid_o at cycle 18 with erro=1, criterio=4.
- **Backpressure:** hold sel_ready_in=0 for 5 cycles in ENTREGA and pulse sel_req_in meanwhile → outputs stay constant and no new atualizar pulse; after ready=1, OCIOSO on the next cycle and a fresh request is accepted.
